bp_cce_lce_req_in: RTL

- CCE-side receiver for LCE request messages (uc_rd, uc_wr, rd_miss, wr_miss) issued by the LCE request handlers.
- Accepts BedRock LCE request messages over a ready-valid port and buffers them in a small FIFO.
- Presents decoded request fields to the CCE pipeline over a valid-yumi port.
- Tracks outstanding requests per source LCE and raises a sticky protocol-error flag on misuse.

---
 rtl/bp_cce_lce_req_in.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/bp_cce_lce_req_in.sv
// CCE-side receiver for LCE request messages (uc_rd, uc_wr, rd_miss, wr_miss).
// Buffers incoming BedRock request messages in a small FIFO and drops misrouted
// or malformed heads. It presents decoded fields on a valid-yumi port, tracks
// outstanding requests per LCE, and keeps a sticky protocol-error flag.
//
// Optional statistics counters are enabled with `define BP_CCE_LCE_REQ_IN_STATS_EN.
//
// Message layout, LSB first:
//   msg_type[3] | addr[paddr] | size[3] | dst_id[cce_id] | src_id[lce_id] |
//   lru_way_id[lg_assoc] | non_exclusive[1] | data[cce_block_width]
// msg_type encoding: 0=rd_miss 1=wr_miss 2=uc_rd 3=uc_wr, 4..7 not accepted here.
//
// state   | meaning
// e_reset | first cycle after reset release, ready held low
// e_ready | ready follows FIFO space
module bp_cce_lce_req_in #(
    parameter int paddr_width_p     = 40,
    parameter int lce_id_width_p    = 4,
    parameter int cce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int cce_block_width_p = 64,
    parameter int num_lce_p         = 4,
    parameter int dword_width_gp    = 64,
    parameter int fifo_els_p        = 2,
    parameter int credits_p         = 2,
    localparam int lg_assoc_lp          = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    localparam int hdr_width_lp         = 3 + paddr_width_p + 3 + cce_id_width_p
                                          + lce_id_width_p + lg_assoc_lp + 1,
    localparam int lce_req_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_id_width_p-1:0]       cce_id_i,
    input  logic [lce_req_msg_width_lp-1:0] lce_req_i,
    input  logic                            lce_req_v_i,
    output logic                            lce_req_ready_and_o,
    output logic                            req_v_o,
    output logic [1:0]                      req_type_o,
    output logic [paddr_width_p-1:0]        req_addr_o,
    output logic [2:0]                      req_size_o,
    output logic [lce_id_width_p-1:0]       req_lce_id_o,
    output logic [lg_assoc_lp-1:0]          req_lru_way_o,
    output logic                            req_non_excl_o,
    output logic [dword_width_gp-1:0]       req_data_o,
    input  logic                            req_yumi_i,
    input  logic                            done_v_i,
    input  logic [lce_id_width_p-1:0]       done_lce_id_i,
    output logic [num_lce_p-1:0]            pending_o,
    output logic                            error_o,
    output logic [31:0]                     stat_uc_rd_o,
    output logic [31:0]                     stat_uc_wr_o,
    output logic [31:0]                     stat_rd_miss_o,
    output logic [31:0]                     stat_wr_miss_o
);

    localparam int addr_lsb_lp = 3;
    localparam int size_lsb_lp = addr_lsb_lp + paddr_width_p;
    localparam int dst_lsb_lp  = size_lsb_lp + 3;
    localparam int src_lsb_lp  = dst_lsb_lp + cce_id_width_p;
    localparam int lru_lsb_lp  = src_lsb_lp + lce_id_width_p;
    localparam int ne_lsb_lp   = lru_lsb_lp + lg_assoc_lp;
    localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int fcnt_w_lp   = $clog2(fifo_els_p + 1);
    localparam int cnt_w_lp    = $clog2(credits_p + 1);

    typedef enum logic [1:0] {
        e_reset = 2'b00,
        e_ready = 2'b01
    } state_e;

    state_e                          state_r;
    logic [lce_req_msg_width_lp-1:0] mem_r [fifo_els_p];
    logic [ptr_w_lp-1:0]             wr_ptr_r, rd_ptr_r;
    logic [fcnt_w_lp-1:0]            fcnt_r, fcnt_next;
    logic [cnt_w_lp-1:0]             cnt_r [num_lce_p];
    logic [cnt_w_lp-1:0]             cnt_next [num_lce_p];
    logic [num_lce_p-1:0]            inc_vec, dec_vec;
    logic [lce_req_msg_width_lp-1:0] head;
    logic [2:0]                      head_type;
    logic                            empty, head_ok, drop, enq, deq, yumi_fire;
    logic                            cnt_err, id_err, error_r;

    assign empty     = (fcnt_r == '0);
    assign head      = mem_r[rd_ptr_r];
    assign head_type = head[2:0];
    assign head_ok   = (head[dst_lsb_lp +: cce_id_width_p] == cce_id_i) && !head_type[2];

    assign req_v_o   = !empty && head_ok;
    assign drop      = !empty && !head_ok;
    assign yumi_fire = req_yumi_i && req_v_o;
    assign enq       = lce_req_v_i && lce_req_ready_and_o;
    assign deq       = drop || yumi_fire;

    // rd_miss(0)->2, wr_miss(1)->3, uc_rd(2)->0, uc_wr(3)->1
    assign req_type_o     = {~head_type[1], head_type[0]};
    assign req_addr_o     = head[addr_lsb_lp +: paddr_width_p];
    assign req_size_o     = head[size_lsb_lp +: 3];
    assign req_lce_id_o   = head[src_lsb_lp +: lce_id_width_p];
    assign req_lru_way_o  = head[lru_lsb_lp +: lg_assoc_lp];
    assign req_non_excl_o = head[ne_lsb_lp];
    assign req_data_o     = head[hdr_width_lp +: dword_width_gp];
    assign error_o        = error_r;

    // Next FIFO occupancy, used to register ready one cycle ahead
    always_comb begin
        fcnt_next = fcnt_r;
        case ({enq, deq})
            2'b10:   fcnt_next = fcnt_r + 1'b1;
            2'b01:   fcnt_next = fcnt_r - 1'b1;
            default: fcnt_next = fcnt_r;
        endcase
    end

    // Sequencing FSM; ready is registered so it never depends on req_yumi_i combinationally
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r             <= e_reset;
            lce_req_ready_and_o <= 1'b0;
        end else begin
            case (state_r)
                e_reset: begin
                    state_r             <= e_ready;
                    lce_req_ready_and_o <= (fcnt_next != fcnt_w_lp'(fifo_els_p));
                end
                e_ready: begin
                    state_r             <= e_ready;
                    lce_req_ready_and_o <= (fcnt_next != fcnt_w_lp'(fifo_els_p));
                end
                default: begin
                    state_r             <= e_reset;
                    lce_req_ready_and_o <= 1'b0;
                end
            endcase
        end
    end

    // Input FIFO storage and pointers; storage is cleared so outputs read 0 out of reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < fifo_els_p; i++) mem_r[i] <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fcnt_r   <= '0;
        end else begin
            if (enq) begin
                mem_r[wr_ptr_r] <= lce_req_i;
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
            end
            if (deq) begin
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
            end
            fcnt_r <= fcnt_next;
        end
    end

    // Per-LCE increment/decrement strobes
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            inc_vec[i] = yumi_fire && (int'(req_lce_id_o) == i);
            dec_vec[i] = done_v_i && (int'(done_lce_id_i) == i);
        end
    end

    // Next outstanding counts: saturate on overflow, hold at 0 on underflow, flag both
    always_comb begin
        cnt_err = 1'b0;
        for (int i = 0; i < num_lce_p; i++) begin
            cnt_next[i] = cnt_r[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt_r[i] == cnt_w_lp'(credits_p)) cnt_err = 1'b1;
                else                                   cnt_next[i] = cnt_r[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt_r[i] == '0) cnt_err = 1'b1;
                else                cnt_next[i] = cnt_r[i] - 1'b1;
            end
        end
    end

    // An LCE id with no counter behind it is also treated as protocol misuse
    assign id_err = (yumi_fire && (int'(req_lce_id_o) >= num_lce_p))
                 || (done_v_i && (int'(done_lce_id_i) >= num_lce_p));

    // Outstanding counters and sticky error flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_lce_p; i++) cnt_r[i] <= '0;
            error_r <= 1'b0;
        end else begin
            for (int i = 0; i < num_lce_p; i++) cnt_r[i] <= cnt_next[i];
            error_r <= error_r || drop || cnt_err || id_err;
        end
    end

    // Pending flags from nonzero outstanding counts
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < num_lce_p; i++) pending_o[i] = (cnt_r[i] != '0);
    end

`ifdef BP_CCE_LCE_REQ_IN_STATS_EN
    logic [31:0] stat_r [4];

    // Saturating per-type consume counters, indexed by req_type_o
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 4; i++) stat_r[i] <= '0;
        end else if (yumi_fire && (stat_r[req_type_o] != 32'hFFFF_FFFF)) begin
            stat_r[req_type_o] <= stat_r[req_type_o] + 32'd1;
        end
    end

    assign stat_uc_rd_o   = stat_r[0];
    assign stat_uc_wr_o   = stat_r[1];
    assign stat_rd_miss_o = stat_r[2];
    assign stat_wr_miss_o = stat_r[3];
`else
    assign stat_uc_rd_o   = '0;
    assign stat_uc_wr_o   = '0;
    assign stat_rd_miss_o = '0;
    assign stat_wr_miss_o = '0;
`endif

    // The consumer may only yumi a presented request
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       req_yumi_i |-> req_v_o);

endmodule
